// File: rtl/msrv32_decode_pkg.sv
// Shared constants and opcode decode for the msrv32 decode stage.
package msrv32_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_Z    = 3'b110;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [2:0] imm_type;
        logic       illegal;
    } dec_t;

    // One buffered instruction with its decode results stored alongside.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_type;
        logic        illegal;
    } entry_t;

    // Opcode -> immediate type; f3_msb is instr[14], selecting the CSR zimm form.
    function automatic dec_t decode_op(input logic [6:0] opcode, input logic f3_msb);
        dec_t d;
        d.imm_type = IMM_NONE;
        d.illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: d.imm_type = IMM_I;
            OPC_STORE:            d.imm_type = IMM_S;
            OPC_BRANCH:           d.imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:   d.imm_type = IMM_U;
            OPC_JAL:              d.imm_type = IMM_J;
            OPC_SYSTEM:           d.imm_type = f3_msb ? IMM_Z : IMM_I;
            OPC_OP:               d.imm_type = IMM_NONE;
            default:              d.illegal  = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/msrv32_decode_ctrl_imm_gen.sv
// Immediate generator: expands instr[31:7] into a 32-bit immediate by type.
import msrv32_decode_pkg::*;

module msrv32_imm_generator (
    input  logic [31:7] instr,
    input  logic [2:0]  imm_type,
    output logic [31:0] imm
);

    // Pure combinational select; unknown/none types yield zero.
    always_comb begin
        imm = 32'h0;
        case (imm_type)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z: imm = {27'h0, instr[19:15]};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/msrv32_decode_ctrl.sv
// Decode-stage controller: two-entry skid buffer between fetch and execute,
// with decode on capture, registered ready, flush and a saturating stall counter.
import msrv32_decode_pkg::*;

module msrv32_decode_ctrl #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             flush_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic [2:0]       imm_type_out,
    output logic [31:0]      imm_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] stall_cnt_out
);

    entry_t           head, skid, incoming;
    logic             head_valid, skid_valid, ready_q;
    logic             head_valid_n, skid_valid_n;
    logic             load_head, load_skid, move_skid;
    logic             accept, pop;
    logic [CNT_W-1:0] stall_cnt;
    dec_t             dec_in;

    assign dec_in   = decode_op(instr_in[6:0], instr_in[14]);
    assign incoming = '{instr: instr_in, pc: pc_in,
                        imm_type: dec_in.imm_type, illegal: dec_in.illegal};

    assign accept = valid_in & ready_q;
    assign pop    = head_valid & ready_in;

    // Buffer control: decide valid bits and which payload moves this edge.
    always_comb begin
        head_valid_n = head_valid;
        skid_valid_n = skid_valid;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        if (flush_in) begin
            head_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (skid_valid) begin
            // ready_q is low here, so no accept can coincide with the drain.
            if (pop) begin
                move_skid    = 1'b1;
                skid_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!head_valid || pop) begin
                load_head    = 1'b1;
                head_valid_n = 1'b1;
            end else begin
                load_skid    = 1'b1;
                skid_valid_n = 1'b1;
            end
        end else if (pop) begin
            head_valid_n = 1'b0;
        end
    end

    // Valid bits and the registered ready (mirror of the next skid state).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            head_valid <= head_valid_n;
            skid_valid <= skid_valid_n;
            ready_q    <= ~skid_valid_n;
        end
    end

    // Payload registers; they only change on capture, so they hold otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= '{instr: NOP, pc: RESET_PC, imm_type: IMM_NONE, illegal: 1'b0};
            skid <= '{instr: NOP, pc: RESET_PC, imm_type: IMM_NONE, illegal: 1'b0};
        end else begin
            if (load_head)      head <= incoming;
            else if (move_skid) head <= skid;
            if (load_skid)      skid <= incoming;
        end
    end

    // Stall-cycle counter, saturating; only reset clears it.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            stall_cnt <= '0;
        else if (head_valid && !ready_in && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

    msrv32_imm_generator u_imm (
        .instr    (head.instr[31:7]),
        .imm_type (head.imm_type),
        .imm      (imm_out)
    );

    assign ready_out     = ready_q;
    assign valid_out     = head_valid;
    assign instr_out     = head.instr;
    assign pc_out        = head.pc;
    assign imm_type_out  = head.imm_type;
    assign illegal_out   = head.illegal;
    assign stall_cnt_out = stall_cnt;

endmodule

// File: tb/tb_msrv32_decode_ctrl.sv
// Self-checking bench for msrv32_decode_ctrl: decode table plus skid/flush/stall sequences.
module tb_msrv32_decode_ctrl;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic             clk_in = 1'b0;
    logic             rst_in, valid_in, flush_in, ready_in;
    logic [31:0]      instr_in, pc_in;
    logic             ready_out, valid_out, illegal_out;
    logic [31:0]      instr_out, pc_out, imm_out;
    logic [2:0]       imm_type_out;
    logic [CNT_W-1:0] stall_cnt_out;

    int passed = 0;
    int total  = 0;

    always #5 clk_in = ~clk_in;

    msrv32_decode_ctrl #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .flush_in      (flush_in),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .imm_type_out  (imm_type_out),
        .imm_out       (imm_out),
        .illegal_out   (illegal_out),
        .stall_cnt_out (stall_cnt_out)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  ty;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        valid_in = 1'b1;
        instr_in = i;
        pc_in    = p;
    endtask

    initial begin
        vt[0] = '{32'hFFF0_0093, 32'h100, 3'b001, 32'hFFFF_FFFF, 1'b0}; // ADDI -1
        vt[1] = '{32'h1234_5037, 32'h104, 3'b100, 32'h1234_5000, 1'b0}; // LUI
        vt[2] = '{32'h0080_00EF, 32'h108, 3'b101, 32'h0000_0008, 1'b0}; // JAL +8
        vt[3] = '{32'h3401_D073, 32'h10C, 3'b110, 32'h0000_0003, 1'b0}; // CSRRWI
        vt[4] = '{32'h0020_81B3, 32'h110, 3'b000, 32'h0000_0000, 1'b0}; // ADD
        vt[5] = '{32'h0000_007F, 32'h114, 3'b000, 32'h0000_0000, 1'b1}; // bad opcode
        vt[6] = '{32'h0000_0000, 32'h118, 3'b000, 32'h0000_0000, 1'b1}; // bits[1:0]=00
        vt[7] = '{32'h3401_1073, 32'h11C, 3'b001, 32'h0000_0340, 1'b0}; // CSRRW -> I
        vt[8] = '{32'hFE11_2E23, 32'h120, 3'b010, 32'hFFFF_FFFC, 1'b0}; // SW -4

        rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
        instr_in = 32'h0; pc_in = 32'h0;
        tick(); tick();
        chk("rst_valid",    32'(valid_out),     32'd0);
        chk("rst_ready",    32'(ready_out),     32'd1);
        chk("rst_instr",    instr_out,          32'h0000_0013);
        chk("rst_pc",       pc_out,             RESET_PC);
        chk("rst_type",     32'(imm_type_out),  32'd0);
        chk("rst_ill",      32'(illegal_out),   32'd0);
        chk("rst_imm",      imm_out,            32'd0);
        chk("rst_stall",    32'(stall_cnt_out), 32'd0);
        rst_in = 1'b0;

        // Back-to-back stream with ready_in high: one result per cycle.
        for (int k = 0; k < 9; k++) begin
            offer(vt[k].instr, vt[k].pc);
            tick();
            chk($sformatf("tab%0d_valid", k), 32'(valid_out),    32'd1);
            chk($sformatf("tab%0d_instr", k), instr_out,         vt[k].instr);
            chk($sformatf("tab%0d_pc", k),    pc_out,            vt[k].pc);
            chk($sformatf("tab%0d_type", k),  32'(imm_type_out), 32'(vt[k].ty));
            chk($sformatf("tab%0d_imm", k),   imm_out,           vt[k].imm);
            chk($sformatf("tab%0d_ill", k),   32'(illegal_out),  32'(vt[k].ill));
        end
        valid_in = 1'b0;
        tick();
        chk("drain_valid", 32'(valid_out), 32'd0);
        chk("drain_hold",  instr_out,      32'hFE11_2E23);

        // Skid fill under backpressure, then drain in order.
        ready_in = 1'b0;
        offer(32'h0011_2623, 32'h200);              // SW imm 12
        tick();
        chk("sk_ready1", 32'(ready_out), 32'd1);
        chk("sk_valid1", 32'(valid_out), 32'd1);
        offer(32'h0020_8463, 32'h204);              // BEQ imm 8
        tick();
        chk("sk_ready2", 32'(ready_out), 32'd0);
        chk("sk_head2",  instr_out,      32'h0011_2623);
        offer(32'h0050_0113, 32'h208);              // ADDI imm 5, stalled
        tick();
        chk("sk_ready3", 32'(ready_out),    32'd0);
        chk("sk_sw",     instr_out,         32'h0011_2623);
        chk("sk_sw_imm", imm_out,           32'h0000_000C);
        chk("sk_sw_ty",  32'(imm_type_out), 32'd2);
        ready_in = 1'b1;
        tick();
        chk("sk_beq",     instr_out,         32'h0020_8463);
        chk("sk_beq_pc",  pc_out,            32'h204);
        chk("sk_beq_imm", imm_out,           32'h0000_0008);
        chk("sk_beq_ty",  32'(imm_type_out), 32'd3);
        chk("sk_ready4",  32'(ready_out),    32'd1);
        tick();
        chk("sk_third",     instr_out, 32'h0050_0113);
        chk("sk_third_pc",  pc_out,    32'h208);
        chk("sk_third_imm", imm_out,   32'h0000_0005);
        valid_in = 1'b0;
        tick();
        chk("sk_empty", 32'(valid_out), 32'd0);

        // Flush with head and skid full plus a concurrent offer.
        ready_in = 1'b0;
        offer(32'h0010_0093, 32'h300);
        tick();
        offer(32'h0020_0093, 32'h304);
        tick();
        chk("fl_full_ready", 32'(ready_out), 32'd0);
        flush_in = 1'b1;
        offer(32'h0030_0093, 32'h308);
        tick();
        flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        chk("fl_valid", 32'(valid_out), 32'd0);
        chk("fl_ready", 32'(ready_out), 32'd1);
        chk("fl_hold",  instr_out,      32'h0010_0093);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_quiet%0d", k), 32'(valid_out), 32'd0);
        end

        // Flush while ready is high: the offered instruction must be dropped.
        ready_in = 1'b0;
        offer(32'h0040_0093, 32'h30C);
        tick();
        flush_in = 1'b1;
        offer(32'h0050_0093, 32'h310);
        tick();
        flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        chk("fl2_valid", 32'(valid_out), 32'd0);
        chk("fl2_hold",  instr_out,      32'h0040_0093);
        tick();
        chk("fl2_quiet", 32'(valid_out), 32'd0);

        // Stall counter saturation, flush persistence, reset clear.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("st_rst", 32'(stall_cnt_out), 32'd0);
        ready_in = 1'b0;
        offer(32'h0010_0093, 32'h400);
        tick();
        valid_in = 1'b0;
        chk("st_start", 32'(stall_cnt_out), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 9) chk("st_mid", 32'(stall_cnt_out), 32'd10);
        end
        chk("st_sat", 32'(stall_cnt_out), 32'd15);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("st_flush", 32'(stall_cnt_out), 32'd15);
        chk("st_flush_valid", 32'(valid_out), 32'd0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("st_clear", 32'(stall_cnt_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
